mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl_if.sv | 51 +++++
 rtl/mem_timeout_cnt.sv | 31 +++
 rtl/mem_access_ctrl.sv | 115 +++++++++++
 tb/tb_mem_access_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data memory access controller.
// State encoding, default timeout and timeout counter width.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W       = 8;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and memory-side signals of the MEM-stage access controller.
// slave = controller view, master = pipeline/memory environment view.
interface mem_access_ctrl_if;

    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        MemStall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    modport slave (
        input  MemRead_i,
        input  MemWrite_i,
        input  addr_i,
        input  wdata_i,
        input  mem_ack_i,
        input  mem_rdata_i,
        output rdata_o,
        output MemStall_o,
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output err_o
    );

    modport master (
        output MemRead_i,
        output MemWrite_i,
        output addr_i,
        output wdata_i,
        output mem_ack_i,
        output mem_rdata_i,
        input  rdata_o,
        input  MemStall_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  err_o
    );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter for one memory access.
// expired is asserted in the LIMIT-th enabled cycle after a clear.
module mem_timeout_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: stalls the pipeline around each access.
// Optional posted write buffer: define MEM_ACCESS_CTRL_WBUF_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_access_ctrl_if.slave   bus
);

    state_t      state;
    logic        posted;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        any_req;
    logic        post;
    logic        take;
    logic        cnt_en;
    logic        expired;
    logic        stall;

    assign any_req = bus.MemRead_i | bus.MemWrite_i;
    assign take    = (state == ST_IDLE) && any_req;
    assign cnt_en  = (state == ST_REQ);

`ifdef MEM_ACCESS_CTRL_WBUF_EN
    // a store with both strobes set is still a store, so it may be posted
    assign post = bus.MemWrite_i;
`else
    assign post = 1'b0;
`endif

    mem_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (take),
        .enable  (cnt_en),
        .expired (expired)
    );

    // posted drains only freeze the pipe when another access is waiting
    always_comb begin
        stall = 1'b0;
        unique case (state)
            ST_IDLE: stall = any_req & ~post;
            ST_REQ:  stall = ~posted | any_req;
            ST_DONE: stall = posted & any_req;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            posted  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_REQ;
                        req_q   <= 1'b1;
                        we_q    <= bus.MemWrite_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        posted  <= post;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ack_i) begin
                        state <= ST_DONE;
                        req_q <= 1'b0;
                        if (!we_q) rdata_q <= bus.mem_rdata_i;
                    end else if (expired) begin
                        state <= ST_DONE;
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        if (!we_q) rdata_q <= '0;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    posted <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    req_q  <= 1'b0;
                    posted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MemStall_o  = rst_i & stall;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT=4).
// Inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_access_ctrl;

    logic clk;
    logic rst_n;
    int   vec;
    int   bad;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(
        .TIMEOUT (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        bus.MemRead_i   = 1'b0;
        bus.MemWrite_i  = 1'b0;
        bus.addr_i      = 32'h0;
        bus.wdata_i     = 32'h0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0BAD_F00D;
    endtask

    // drives one access until the stall drops; returns at negedge of that cycle
    task automatic run_access(
        input  logic        rd,
        input  logic        wr,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic        exp_we,
        input  int          ack_at,
        input  logic [31:0] rv,
        output int          stalls,
        output int          reqs,
        output logic        stable
    );
        bit fin;
        stalls = 0;
        reqs   = 0;
        stable = 1'b1;
        fin    = 1'b0;
        @(posedge clk); #1;
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        bus.addr_i     = a;
        bus.wdata_i    = d;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            bus.mem_ack_i   = bus.mem_req_o && (reqs + 1 == ack_at);
            bus.mem_rdata_i = bus.mem_ack_i ? rv : 32'h0BAD_F00D;
            @(negedge clk);
            if (bus.MemStall_o) stalls++;
            if (bus.mem_req_o) begin
                reqs++;
                if (bus.mem_addr_o !== a || bus.mem_we_o !== exp_we ||
                    bus.mem_wdata_o !== d)
                    stable = 1'b0;
            end
            if (!bus.MemStall_o && c > 0) fin = 1'b1;
        end
        if (!fin) stalls = -1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.MemRead_i = 1'b1;
        #3;
        vec++;
        if (bus.MemStall_o !== 1'b0) begin
            bad++; $display("FAIL rst_stall got %b want 0", bus.MemStall_o);
        end
        @(negedge clk);
        @(negedge clk);
        vec++;
        if (bus.mem_req_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_req_we got %b%b want 00", bus.mem_req_o, bus.mem_we_o);
        end
        vec++;
        if (bus.rdata_o !== 32'h0 || bus.mem_addr_o !== 32'h0 ||
            bus.mem_wdata_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_data got %h/%h/%h want 0", bus.rdata_o,
                     bus.mem_addr_o, bus.mem_wdata_o);
        end
        vec++;
        if (bus.err_o !== 1'b0) begin
            bad++; $display("FAIL rst_err got %b want 0", bus.err_o);
        end
        bus.MemRead_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        int s, r;
        logic st;
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 3, 32'hDEAD_BEEF, s, r, st);
        vec++;
        if (s !== 4) begin
            bad++; $display("FAIL load_stall got %0d want 4", s);
        end
        vec++;
        if (r !== 3) begin
            bad++; $display("FAIL load_reqs got %0d want 3", r);
        end
        vec++;
        if (st !== 1'b1) begin
            bad++; $display("FAIL load_stable got %b want 1", st);
        end
        vec++;
        if (bus.rdata_o !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load_rdata got %h want deadbeef", bus.rdata_o);
        end
        vec++;
        if (bus.err_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL load_done got err=%b req=%b want 0 0", bus.err_o, bus.mem_req_o);
        end
    endtask

    task automatic test_store();
        int s, r;
        logic st;
        run_access(1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b1, 1, 32'hFFFF_0000,
                   s, r, st);
        vec++;
        if (s !== 2) begin
            bad++; $display("FAIL store_stall got %0d want 2", s);
        end
        vec++;
        if (r !== 1 || st !== 1'b1) begin
            bad++; $display("FAIL store_req got reqs=%0d stable=%b want 1 1", r, st);
        end
        vec++;
        if (bus.rdata_o !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL store_rdata got %h want deadbeef", bus.rdata_o);
        end
    endtask

    task automatic test_both_high();
        int s, r;
        logic st;
        run_access(1'b1, 1'b1, 32'h24, 32'hA5A5_5A5A, 1'b1, 2, 32'h7777_7777,
                   s, r, st);
        vec++;
        if (s !== 3 || r !== 2) begin
            bad++; $display("FAIL both_timing got stall=%0d reqs=%0d want 3 2", s, r);
        end
        vec++;
        if (st !== 1'b1) begin
            bad++; $display("FAIL both_we got stable=%b want 1", st);
        end
        vec++;
        if (bus.rdata_o !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL both_rdata got %h want deadbeef", bus.rdata_o);
        end
    endtask

    task automatic test_timeout();
        int s, r;
        logic st;
        run_access(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 0, 32'h0, s, r, st);
        vec++;
        if (s !== 5 || r !== 4) begin
            bad++; $display("FAIL tmo_timing got stall=%0d reqs=%0d want 5 4", s, r);
        end
        vec++;
        if (bus.err_o !== 1'b1 || bus.rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL tmo_result got err=%b rdata=%h want 1 0", bus.err_o, bus.rdata_o);
        end
        @(negedge clk);
        vec++;
        if (bus.MemStall_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL tmo_idle got stall=%b req=%b want 0 0", bus.MemStall_o, bus.mem_req_o);
        end
        run_access(1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 1, 32'h0000_00C3, s, r, st);
        vec++;
        if (bus.err_o !== 1'b1 || bus.rdata_o !== 32'h0000_00C3) begin
            bad++;
            $display("FAIL tmo_sticky got err=%b rdata=%h want 1 c3", bus.err_o, bus.rdata_o);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.MemRead_i = 1'b1;
        bus.addr_i    = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec++;
        if (bus.mem_req_o !== 1'b1 || bus.MemStall_o !== 1'b1) begin
            bad++;
            $display("FAIL rmid_pre got req=%b stall=%b want 1 1", bus.mem_req_o, bus.MemStall_o);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if (bus.mem_req_o !== 1'b0 || bus.MemStall_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_now got req=%b stall=%b want 0 0", bus.mem_req_o, bus.MemStall_o);
        end
        vec++;
        if (bus.err_o !== 1'b0 || bus.mem_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL rmid_clr got err=%b addr=%h want 0 0", bus.err_o, bus.mem_addr_o);
        end
        @(negedge clk);
        bus.MemRead_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        vec++;
        if (bus.MemStall_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_ack got stall=%b req=%b want 0 0", bus.MemStall_o, bus.mem_req_o);
        end
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.rdata_o !== 32'h0 || bus.mem_req_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_after got rdata=%h req=%b want 0 0", bus.rdata_o, bus.mem_req_o);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        bus.MemRead_i = 1'b1;
        bus.addr_i    = 32'h100;
        @(posedge clk); #1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1111_1111;
        @(posedge clk); #1;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0BAD_F00D;
        bus.addr_i      = 32'h104;
        @(negedge clk);
        vec++;
        if (bus.mem_req_o !== 1'b0 || bus.MemStall_o !== 1'b0 ||
            bus.rdata_o !== 32'h1111_1111) begin
            bad++;
            $display("FAIL b2b_done got req=%b stall=%b rdata=%h want 0 0 11111111",
                     bus.mem_req_o, bus.MemStall_o, bus.rdata_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vec++;
        if (bus.mem_req_o !== 1'b0 || bus.MemStall_o !== 1'b1 ||
            bus.mem_addr_o !== 32'h100) begin
            bad++;
            $display("FAIL b2b_idle got req=%b stall=%b addr=%h want 0 1 100",
                     bus.mem_req_o, bus.MemStall_o, bus.mem_addr_o);
        end
        @(posedge clk); #1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h2222_2222;
        @(negedge clk);
        vec++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h104) begin
            bad++;
            $display("FAIL b2b_req2 got req=%b addr=%h want 1 104", bus.mem_req_o, bus.mem_addr_o);
        end
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        bus.MemRead_i = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.rdata_o !== 32'h2222_2222 || bus.MemStall_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done2 got rdata=%h stall=%b want 22222222 0",
                     bus.rdata_o, bus.MemStall_o);
        end
    endtask

`ifdef MEM_ACCESS_CTRL_WBUF_EN
    task automatic test_wbuf();
        @(posedge clk); #1;
        bus.MemWrite_i = 1'b1;
        bus.addr_i     = 32'h300;
        bus.wdata_i    = 32'h0000_CAFE;
        @(negedge clk);
        vec++;
        if (bus.MemStall_o !== 1'b0) begin
            bad++; $display("FAIL wbuf_post got stall=%b want 0", bus.MemStall_o);
        end
        @(posedge clk); #1;
        bus.MemWrite_i = 1'b0;
        bus.MemRead_i  = 1'b1;
        bus.addr_i     = 32'h304;
        bus.mem_ack_i  = 1'b1;
        @(negedge clk);
        vec++;
        if (bus.MemStall_o !== 1'b1 || bus.mem_we_o !== 1'b1 ||
            bus.mem_addr_o !== 32'h300) begin
            bad++;
            $display("FAIL wbuf_drain got stall=%b we=%b addr=%h want 1 1 300",
                     bus.MemStall_o, bus.mem_we_o, bus.mem_addr_o);
        end
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.MemStall_o !== 1'b1) begin
            bad++; $display("FAIL wbuf_hold got stall=%b want 1", bus.MemStall_o);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h5555_5555;
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        bus.MemRead_i = 1'b0;
        @(negedge clk);
        vec++;
        if (bus.rdata_o !== 32'h5555_5555 || bus.MemStall_o !== 1'b0) begin
            bad++;
            $display("FAIL wbuf_load got rdata=%h stall=%b want 55555555 0",
                     bus.rdata_o, bus.MemStall_o);
        end
    endtask
`endif

    initial begin
        vec = 0;
        bad = 0;
        test_reset();
        test_load();
`ifndef MEM_ACCESS_CTRL_WBUF_EN
        test_store();
        test_both_high();
`endif
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_ACCESS_CTRL_WBUF_EN
        test_wbuf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
